i_encoder: RTL and testbench
============================

Name: i_encoder

Overview:
Inverse of the instruction decoder. Accepts decoded RV64 fields (rd, rs1, rs2, imm, funct3, funct7, opcode, format) over a valid/ready handshake and packs them into a 32-bit instruction word. Each packed word is emitted through a registered valid/ready output, tagged with a running instruction-memory address.
- Used by the program loader and self-test sequencer to build instruction-memory images.
- Used by the bench for round-trip checks: decode(encode(x)) == x.

Parameters:
- BASE_ADDR, 64'h0, address assigned to the first emitted word after reset or clear.
- ADDR_STEP, 4, address increment per emitted word.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  64  sign-extended immediate, same layout the decoder produces
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type only)
- in_opcode  in  7  opcode, inserted verbatim into bits [6:0]
- in_format  in  3  R=0 I=1 S=2 B=3 U=4 J=5; 6 and 7 are illegal
- clear  in  1  synchronous: reset the address counter and error state
- out_valid  out  1  out_instr is valid
- out_ready  in  1  consumer accepts the word
- out_instr  out  32  encoded instruction
- out_addr  out  64  address of out_instr
- err_sticky  out  1  set on any dropped bundle
- err_cnt  out  ERR_CNT_W  count of dropped bundles, saturating

Behaviour:
- Reset (async, rst=1): out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_sticky=0, err_cnt=0.
- in_ready = !out_valid || out_ready. This is a single output register with no skid buffer. Accept happens on in_valid && in_ready.
- Latency: a bundle accepted in cycle N gives out_valid=1 in cycle N+1.
- out_instr, out_addr and out_valid stay stable while out_valid && !out_ready.
- The address register holds the address of the next word to emit.
  - out_addr takes that value when a word loads.
  - The next-address register advances by ADDR_STEP on each load into the output register. It wraps modulo 2^64.
- Packing is selected by in_format; the opcode is never reinterpreted.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}. funct7 is ignored; shift encodings must carry funct7 in imm[11:5].
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}. This applies to any opcode given format 5, including JALR, to match the decoder.
- Legality checks on the accepted bundle:
  - format 6 or 7 is illegal.
  - I/S: imm must equal sext(imm[11:0]).
  - B: imm[0]==0 and imm must equal sext(imm[12:0]).
  - U: imm[11:0]==0 and imm must equal sext(imm[31:0]).
  - J: imm[0]==0 and imm must equal sext(imm[20:0]).
  - R: imm is ignored.
- Illegal bundle handling:
  - The bundle is still accepted (in_ready rules unchanged) and is dropped.
  - The output register is not loaded; an existing word that is not yet consumed is preserved.
  - Address does not advance.
  - err_sticky is set and err_cnt increments, saturating at all-ones.
- clear=1 sets the next address to BASE_ADDR and zeroes err_sticky and err_cnt. It does not flush out_valid.
- clear with a simultaneous legal accept: the accepted word gets BASE_ADDR and the next address becomes BASE_ADDR+ADDR_STEP.
- clear with a simultaneous illegal accept: clear wins and the counter ends at 0.
- rst asserted mid-transfer discards the pending output word immediately (out_valid=0 asynchronously).

Decomposition:
- Package rv64_isa_pkg holds:
  - format enum fmt_e (FMT_R..FMT_J, FMT_INV=7), shared with the decoder;
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, OP_IMM_32, OP_32);
  - immediate-width constants.
- Sub-module i_encoder_pack is purely combinational: fields in, {instr[31:0], legal} out. The top holds the handshake, output register, address counter and error logic.

Test Plan:
- ADD x3,x1,x2 (fmt 0, funct7 0, funct3 0, opcode 0x33) -> out_instr=0x002081B3, out_addr=0x0 one cycle after accept.
- ADDI x1,x0,-1 (imm=64'hFFFF_FFFF_FFFF_FFFF) then BEQ x0,x0,+8 back-to-back with out_ready=1 -> outputs 0xFFF00093 @0x0, then 0x00000463 @0x4.
- LUI x5 with imm=0x12345000 -> 0x123452B7; JAL x1 with imm=0x800 -> 0x001000EF; round-trip each through the decoder and require identical fields.
- ADDI with imm=2048 and B-type with imm=3 -> both dropped, no out_valid, err_cnt=2, err_sticky=1, next legal word still at the expected address; then clear -> err_cnt=0 and next address=BASE_ADDR.
- out_ready held 0 for 5 cycles with in_valid=1 -> first word held stable, in_ready=0 and no second accept; release -> second word follows at address +4.
- rst pulsed while out_valid=1 -> out_valid=0 in the same cycle and out_addr=BASE_ADDR; the first word after release gets BASE_ADDR.

Source files
------------

// File: rtl/rv64_isa_pkg.sv
// rv64_isa_pkg: RV64 formats, opcodes and immediate widths shared by the encoder and decoder
package rv64_isa_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_INV = 3'd7
    } fmt_e;

    localparam logic [6:0] OP        = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] LOAD      = 7'h03;
    localparam logic [6:0] STORE     = 7'h23;
    localparam logic [6:0] BRANCH    = 7'h63;
    localparam logic [6:0] LUI       = 7'h37;
    localparam logic [6:0] AUIPC     = 7'h17;
    localparam logic [6:0] JAL       = 7'h6F;
    localparam logic [6:0] JALR      = 7'h67;
    localparam logic [6:0] OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OP_32     = 7'h3B;

    localparam int unsigned IMM_I_W = 12;
    localparam int unsigned IMM_S_W = 12;
    localparam int unsigned IMM_B_W = 13;
    localparam int unsigned IMM_U_W = 32;
    localparam int unsigned IMM_J_W = 21;

    // true when v is the sign extension of its low w bits
    function automatic logic fits_signed(input logic [63:0] v, input int unsigned w);
        logic [63:0] t;
        t = $unsigned($signed(v) >>> (w - 1));
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/i_encoder_pack.sv
// i_encoder_pack: combinational packing of decoded fields into a 32-bit word plus legality
module i_encoder_pack
    import rv64_isa_pkg::*;
(
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [63:0] i_imm,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_format,
    output logic [31:0] o_instr,
    output logic        o_legal
);

    // select the bit layout by format; the opcode always passes through untouched
    always_comb begin
        o_instr = '0;
        o_legal = 1'b0;
        case (i_format)
            FMT_R: begin
                o_instr = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                o_legal = 1'b1;
            end
            FMT_I: begin
                o_instr = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_legal = fits_signed(i_imm, IMM_I_W);
            end
            FMT_S: begin
                o_instr = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_legal = fits_signed(i_imm, IMM_S_W);
            end
            FMT_B: begin
                o_instr = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
                o_legal = !i_imm[0] && fits_signed(i_imm, IMM_B_W);
            end
            FMT_U: begin
                o_instr = {i_imm[31:12], i_rd, i_opcode};
                o_legal = (i_imm[11:0] == '0) && fits_signed(i_imm, IMM_U_W);
            end
            FMT_J: begin
                o_instr = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_legal = !i_imm[0] && fits_signed(i_imm, IMM_J_W);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/i_encoder.sv
// i_encoder: handshaked field-to-instruction encoder with address tagging and drop counting
module i_encoder
    import rv64_isa_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter logic [63:0] ADDR_STEP = 64'd4,
    parameter int          ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [63:0]          in_imm,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [6:0]           in_opcode,
    input  logic [2:0]           in_format,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [63:0]          out_addr,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic                 r_valid;
    logic [31:0]          r_instr;
    logic [63:0]          r_addr;
    logic [63:0]          r_next;
    logic                 r_sticky;
    logic [ERR_CNT_W-1:0] r_cnt;
    logic [31:0]          w_instr;
    logic                 w_legal;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_drop;
    logic [63:0]          w_addr;

    i_encoder_pack u_pack (
        .i_rd     (in_rd),
        .i_rs1    (in_rs1),
        .i_rs2    (in_rs2),
        .i_imm    (in_imm),
        .i_funct3 (in_funct3),
        .i_funct7 (in_funct7),
        .i_opcode (in_opcode),
        .i_format (in_format),
        .o_instr  (w_instr),
        .o_legal  (w_legal)
    );

    assign in_ready   = !r_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_load     = w_accept && w_legal;
    assign w_drop     = w_accept && !w_legal;
    assign w_addr     = clear ? BASE_ADDR : r_next;
    assign out_valid  = r_valid;
    assign out_instr  = r_instr;
    assign out_addr   = r_addr;
    assign err_sticky = r_sticky;
    assign err_cnt    = r_cnt;

    // single output register: load a legal word, otherwise empty once consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_addr  <= BASE_ADDR;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_instr <= w_instr;
            r_addr  <= w_addr;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // next-address counter: clear rebases before a same-cycle load takes its address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_next <= BASE_ADDR;
        else if (w_load) r_next <= w_addr + ADDR_STEP;
        else if (clear) r_next <= BASE_ADDR;
    end

    // drop tracking: clear wins over a same-cycle drop; the count saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (clear) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (w_drop) begin
            r_sticky <= 1'b1;
            if (~&r_cnt) r_cnt <= r_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_i_encoder.sv
// tb_i_encoder: directed vectors plus a round-trip scoreboard for i_encoder
module tb_i_encoder;
    import rv64_isa_pkg::*;

    localparam int EW = 4;
    localparam logic [EW-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
    } fld_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [63:0]   in_imm = '0;
    logic [2:0]    in_funct3 = '0;
    logic [6:0]    in_funct7 = '0, in_opcode = '0;
    logic [2:0]    in_format = '0;
    logic          clear = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_instr;
    logic [63:0]   out_addr;
    logic          err_sticky;
    logic [EW-1:0] err_cnt;

    int total = 0;
    int bad = 0;

    i_encoder #(.BASE_ADDR(64'h0), .ADDR_STEP(64'd4), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_opcode(in_opcode),
        .in_format(in_format), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err_sticky(err_sticky), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // extract fields back out of a word, knowing its format
    function automatic fld_t decode(input logic [31:0] w, input logic [2:0] fmt);
        fld_t d;
        d = '{fmt: fmt, op: w[6:0], rd: w[11:7], f3: w[14:12], rs1: w[19:15],
              rs2: w[24:20], f7: w[31:25], imm: 64'h0};
        case (fmt)
            3'd1: d.imm = {{52{w[31]}}, w[31:20]};
            3'd2: d.imm = {{52{w[31]}}, w[31:25], w[11:7]};
            3'd3: d.imm = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4: d.imm = {{32{w[31]}}, w[31:12], 12'h0};
            3'd5: d.imm = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: ;
        endcase
        return d;
    endfunction

    // zero the fields a format does not carry
    function automatic fld_t canon(input fld_t f);
        fld_t c = f;
        case (f.fmt)
            3'd0: c.imm = '0;
            3'd1: begin c.rs2 = '0; c.f7 = '0; end
            3'd2, 3'd3: begin c.rd = '0; c.f7 = '0; end
            default: begin c.rs1 = '0; c.rs2 = '0; c.f3 = '0; c.f7 = '0; end
        endcase
        return c;
    endfunction

    function automatic bit legal(input logic [2:0] f, input logic [63:0] imm);
        longint s = imm;
        case (f)
            3'd0: return 1'b1;
            3'd1, 3'd2: return s >= -2048 && s <= 2047;
            3'd3: return !imm[0] && s >= -4096 && s <= 4095;
            3'd4: return imm[11:0] == 12'h0 && s >= -(longint'(1) << 31) && s < (longint'(1) << 31);
            3'd5: return !imm[0] && s >= -(longint'(1) << 20) && s < (longint'(1) << 20);
            default: return 1'b0;
        endcase
    endfunction

    // scoreboard: words emitted since the last clear give the address
    bit            m_valid;
    fld_t          m_f;
    longint        m_idx, m_k;
    logic [EW-1:0] m_cnt;
    bit            m_sticky;

    always @(negedge clk) begin
        if (rst) begin
            m_valid = 0; m_idx = 0; m_k = 0; m_cnt = '0; m_sticky = 0;
        end else begin
            fld_t cur;
            bit acc, lg;
            chk("sb_valid", 64'(out_valid), 64'(m_valid));
            chk("sb_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
            chk("sb_err_cnt", 64'(err_cnt), 64'(m_cnt));
            chk("sb_err_sticky", 64'(err_sticky), 64'(m_sticky));
            if (m_valid) begin
                chk("sb_addr", out_addr, 64'(m_idx * 4));
                total++;
                if (canon(decode(out_instr, m_f.fmt)) !== canon(m_f)) begin
                    bad++;
                    $display("FAIL sb_roundtrip: got %h want %h", canon(decode(out_instr, m_f.fmt)), canon(m_f));
                end
            end
            cur = '{fmt: in_format, op: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    f3: in_funct3, f7: in_funct7, imm: in_imm};
            acc = in_valid && (!m_valid || out_ready);
            lg = legal(in_format, in_imm);
            if (acc && lg) begin
                m_valid = 1; m_f = cur;
                m_idx = clear ? 0 : m_k;
                m_k = m_idx + 1;
            end else begin
                if (out_ready) m_valid = 0;
                if (clear) m_k = 0;
            end
            if (clear) begin
                m_cnt = '0; m_sticky = 0;
            end else if (acc && !lg) begin
                m_sticky = 1;
                if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
            end
        end
    end

    // called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [63:0] imm, input bit clr);
        bit ok = 0;
        in_format = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; clear = clr; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: got in_ready=0 want 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic expw(input string nm, input logic [31:0] instr, input logic [63:0] addr);
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_instr"}, 64'(out_instr), 64'(instr));
        chk({nm, "_addr"}, out_addr, addr);
    endtask

    logic [2:0]  bad_f   [10] = '{3'd7, 3'd6, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd5};
    logic [63:0] bad_imm [10] = '{64'h0, 64'h0, 64'd2048, -64'sd2049, 64'd3, 64'd4096,
                                  64'h1001, 64'h8000_0000, 64'd1, 64'h10_0000};

    initial begin
        fld_t d;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_addr", out_addr, 64'h0);
        chk("rst_sticky", 64'(err_sticky), 64'd0);
        chk("rst_cnt", 64'(err_cnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(3'd0, OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'h0, 0);
        expw("add", 32'h002081B3, 64'h0);

        send(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        expw("addi_clr", 32'hFFF00093, 64'h0);
        send(3'd3, BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd8, 0);
        expw("beq", 32'h00000463, 64'h4);

        send(3'd4, LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000, 0);
        expw("lui", 32'h123452B7, 64'h8);
        d = decode(out_instr, 3'd4);
        chk("lui_rt_imm", d.imm, 64'h1234_5000);
        chk("lui_rt_rd", 64'(d.rd), 64'd5);
        send(3'd5, JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h800, 0);
        expw("jal", 32'h001000EF, 64'hC);
        d = decode(out_instr, 3'd5);
        chk("jal_rt_imm", d.imm, 64'h800);
        chk("jal_rt_rd", 64'(d.rd), 64'd1);

        send(3'd1, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048, 0);
        chk("drop1_valid", 64'(out_valid), 64'd0);
        send(3'd3, BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3, 0);
        chk("drop2_valid", 64'(out_valid), 64'd0);
        chk("drop_cnt", 64'(err_cnt), 64'd2);
        chk("drop_sticky", 64'(err_sticky), 64'd1);
        send(3'd1, OP_IMM, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 64'd5, 0);
        expw("after_drop", 32'h00508113, 64'h10);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_cnt", 64'(err_cnt), 64'd0);
        chk("clr_sticky", 64'(err_sticky), 64'd0);
        send(3'd2, STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 64'd8, 0);
        expw("sw_after_clr", 32'h0020A423, 64'h0);

        @(posedge clk); #1;
        chk("drain_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        send(3'd0, OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'h0, 0);
        expw("stall_a", 32'h002081B3, 64'h4);
        in_format = 3'd1; in_opcode = OP_IMM; in_rd = 5'd1; in_rs1 = 5'd0;
        in_funct3 = 3'd0; in_imm = 64'hFFFF_FFFF_FFFF_FFFF; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_hold_instr", 64'(out_instr), 64'h002081B3);
            chk("stall_hold_addr", out_addr, 64'h4);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        expw("stall_b", 32'hFFF00093, 64'h8);

        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_addr", out_addr, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(3'd0, OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'h0, 0);
        expw("post_rst", 32'h002081B3, 64'h0);

        for (int i = 0; i < 18; i++)
            send(bad_f[i % 10], OP_IMM, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, bad_imm[i % 10], 0);
        chk("sat_cnt", 64'(err_cnt), 64'(CNT_MAX));
        chk("sat_sticky", 64'(err_sticky), 64'd1);
        chk("sat_valid", 64'(out_valid), 64'd0);
        send(3'd7, OP, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 64'h0, 1);
        chk("clr_drop_cnt", 64'(err_cnt), 64'd0);
        chk("clr_drop_sticky", 64'(err_sticky), 64'd0);
        send(3'd4, LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000, 0);
        expw("lui_after_clr", 32'h123452B7, 64'h0);
        send(3'd1, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -64'sd2048, 0);
        expw("addi_min", 32'h80000013, 64'h4);

        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
